tdd_sync_gate: RTL and testbench

//  Parametrised multi-channel TDD gate for I/Q sample streams. A rising edge on sync_in

---
 rtl/tdd_sync_gate.sv | 140 ++++++++++++++
 tb/tb_tdd_sync_gate.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdd_sync_gate.sv
// Multi-channel TDD gate for I/Q streams: a rising sync_in edge arms a delay, then opens
// the gate for a programmable width. PCOUNT_WIDTH sets the pulse counter width (16 nominal).
module tdd_sync_gate #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CH       = 2,
  parameter int CNT_WIDTH    = 32,
  parameter int PCOUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         cfg_enable,
  input  logic [1:0]                   cfg_mode,
  input  logic [CNT_WIDTH-1:0]         cfg_delay,
  input  logic [CNT_WIDTH-1:0]         cfg_width,
  input  logic                         clr_overrun,
  input  logic                         sync_in,
  input  logic                         data_in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in_I,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in_Q,
  output logic                         data_out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out_I,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out_Q,
  output logic                         sync_out,
  output logic                         busy,
  output logic                         overrun,
  output logic [PCOUNT_WIDTH-1:0]      pulse_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [1:0]              MODE_RETRIG = 2'd1;
  localparam logic [1:0]              MODE_CONT   = 2'd2;
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [PCOUNT_WIDTH-1:0] PC_ONE      = PCOUNT_WIDTH'(1);

  state_t                 state_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [CNT_WIDTH-1:0]   width_r;
  logic                   sync_in_d;

  logic                   edge_s;
  logic                   retrig_s;
  logic                   cont_s;
  logic                   oneshot_s;
  logic                   restart_s;
  logic                   gate_s;
  logic                   overrun_set_s;

  // Trigger qualification; a retrigger with a non-zero delay closes the gate in its own cycle
  always_comb begin
    edge_s        = sync_in & ~sync_in_d;
    retrig_s      = (cfg_mode == MODE_RETRIG);
    cont_s        = (cfg_mode == MODE_CONT);
    oneshot_s     = ~retrig_s & ~cont_s;
    restart_s     = cfg_enable & ~cont_s & edge_s & (cfg_width != '0) &
                    ((state_r == ST_IDLE) | retrig_s);
    gate_s        = cfg_enable & (state_r == ST_ACTIVE) & ~(restart_s & (cfg_delay != '0));
    overrun_set_s = cfg_enable & oneshot_s & edge_s & (state_r != ST_IDLE);
  end

  // Gate FSM, registered datapath and status
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_r        <= ST_IDLE;
      cnt_r          <= '0;
      width_r        <= '0;
      sync_in_d      <= 1'b0;
      data_out_valid <= 1'b0;
      data_out_I     <= '0;
      data_out_Q     <= '0;
      sync_out       <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
      pulse_count    <= '0;
    end else begin
      sync_in_d      <= sync_in;
      data_out_valid <= data_in_valid;
      sync_out       <= gate_s;
      data_out_I     <= gate_s ? data_in_I : '0;
      data_out_Q     <= gate_s ? data_in_Q : '0;

      if (overrun_set_s) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      if (!cfg_enable) begin
        state_r <= ST_IDLE;
        busy    <= 1'b0;
      end else if (cont_s) begin
        if (state_r != ST_ACTIVE) begin
          pulse_count <= pulse_count + PC_ONE;
        end
        state_r <= ST_ACTIVE;
        busy    <= 1'b1;
      end else if (restart_s) begin
        width_r <= cfg_width;
        busy    <= 1'b1;
        if (cfg_delay == '0) begin
          state_r     <= ST_ACTIVE;
          cnt_r       <= cfg_width - CNT_ONE;
          pulse_count <= pulse_count + PC_ONE;
        end else begin
          state_r <= ST_DELAY;
          cnt_r   <= cfg_delay - CNT_ONE;
        end
      end else begin
        case (state_r)
          ST_DELAY: begin
            if (cnt_r == '0) begin
              state_r     <= ST_ACTIVE;
              cnt_r       <= width_r - CNT_ONE;
              pulse_count <= pulse_count + PC_ONE;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          ST_ACTIVE: begin
            if (cnt_r == '0) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdd_sync_gate.sv
// Bench for tdd_sync_gate: a gate-window reference model checked every cycle, plus
// directed scenarios with literal expectations. A 4-bit-counter twin exercises the wrap.
module tb_tdd_sync_gate;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int W  = NC * DW;

  logic          clk;
  logic          rstn;
  logic          cfg_enable;
  logic [1:0]    cfg_mode;
  logic [31:0]   cfg_delay;
  logic [31:0]   cfg_width;
  logic          clr_overrun;
  logic          sync_in;
  logic          data_in_valid;
  logic [W-1:0]  data_in_I;
  logic [W-1:0]  data_in_Q;
  logic          data_out_valid;
  logic [W-1:0]  data_out_I;
  logic [W-1:0]  data_out_Q;
  logic          sync_out;
  logic          busy;
  logic          overrun;
  logic [15:0]   pulse_count;
  logic          w_valid;
  logic [W-1:0]  w_I;
  logic [W-1:0]  w_Q;
  logic          w_sync;
  logic          w_busy;
  logic          w_ovr;
  logic [3:0]    w_count;

  int tests = 0;
  int fails = 0;
  bit data_free = 1'b1;

  tdd_sync_gate #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .clr_overrun(clr_overrun),
    .sync_in(sync_in), .data_in_valid(data_in_valid), .data_in_I(data_in_I),
    .data_in_Q(data_in_Q), .data_out_valid(data_out_valid), .data_out_I(data_out_I),
    .data_out_Q(data_out_Q), .sync_out(sync_out), .busy(busy), .overrun(overrun),
    .pulse_count(pulse_count)
  );

  tdd_sync_gate #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(32), .PCOUNT_WIDTH(4)) dut_w (
    .clk(clk), .rstn(rstn), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .clr_overrun(clr_overrun),
    .sync_in(sync_in), .data_in_valid(data_in_valid), .data_in_I(data_in_I),
    .data_in_Q(data_in_Q), .data_out_valid(w_valid), .data_out_I(w_I),
    .data_out_Q(w_Q), .sync_out(w_sync), .busy(w_busy), .overrun(w_ovr),
    .pulse_count(w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: each accepted trigger defines a window [ws, we] of cycles where
  // sync_out is high, and the cycle inc_at where the gate-open count steps.
  longint cyc = 0;
  longint ws = 0, we = -1, inc_at = -1;
  longint lim;
  logic   m_prev = 1'b0;
  logic   m_ovr = 1'b0;
  int     m_count = 0;
  logic   e_sync, e_busy, e_valid;
  logic [W-1:0] e_I, e_Q;
  logic   m_edge, m_busy_now, m_acc, m_oset;

  always @(posedge clk) begin
    cyc++;
    if (rstn) begin
      m_prev = 1'b0; ws = 0; we = -1; inc_at = -1; m_count = 0; m_ovr = 1'b0;
    end else begin
      m_edge = sync_in && !m_prev;
      m_prev = sync_in;
      e_valid = data_in_valid;
      m_oset = 1'b0;
      if (!cfg_enable) begin
        e_sync = 1'b0; ws = 0; we = -1; inc_at = -1; e_busy = 1'b0;
      end else if (cfg_mode == 2'd2) begin
        e_sync = (ws <= cyc) && (cyc <= we);
        if (!e_sync) begin
          m_count++;
          ws = cyc + 1;
        end
        we = 64'sh7FFF_FFFF_FFFF; inc_at = -1; e_busy = 1'b1;
      end else begin
        m_busy_now = (we >= cyc);
        m_acc = m_edge && (cfg_width != 32'd0) && ((cfg_mode == 2'd1) || !m_busy_now);
        m_oset = m_edge && (cfg_mode != 2'd1) && m_busy_now;
        if (m_acc) begin
          lim = (cfg_delay != 32'd0) ? cyc - 1 : cyc;
          if (lim < we) we = lim;
        end
        e_sync = (ws <= cyc) && (cyc <= we);
        if (m_acc) begin
          ws = cyc + 1 + longint'(cfg_delay);
          we = cyc + longint'(cfg_delay) + longint'(cfg_width);
          inc_at = cyc + longint'(cfg_delay);
        end
        if (inc_at == cyc) m_count++;
        e_busy = (we >= cyc + 1);
      end
      if (m_oset) m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
      e_I = e_sync ? data_in_I : '0;
      e_Q = e_sync ? data_in_Q : '0;
      #1;
      chk("sync_out", sync_out, e_sync);
      chk("busy", busy, e_busy);
      chk("overrun", overrun, m_ovr);
      chk("pulse_count", pulse_count, m_count[15:0]);
      chk("pulse_count_w", w_count, m_count[3:0]);
      chk("sync_out_w", w_sync, e_sync);
      chk("data_out_I", data_out_I, e_I);
      chk("data_out_Q", data_out_Q, e_Q);
      chk("data_out_valid", data_out_valid, e_valid);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (data_free) begin
      data_in_I = {$urandom, $urandom};
      data_in_Q = {$urandom, $urandom};
      data_in_valid = 1'($urandom_range(0, 1));
    end
  endtask

  // Edge sampled at the next posedge (T); optional second edge at T+k2, with clr alongside
  task automatic run_pulse(input int ncyc, input int k2, input logic clr2,
                           output logic [31:0] so, output logic [31:0] bo,
                           output logic [W-1:0] d2);
    so = '0; bo = '0; d2 = '0;
    sync_in = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      so[i] = sync_out;
      bo[i] = busy;
      if (i == 2) d2 = data_out_I;
      sync_in = (k2 > 0 && i == k2 - 1) ? 1'b1 : 1'b0;
      clr_overrun = (k2 > 0 && i == k2 - 1) ? clr2 : 1'b0;
    end
  endtask

  logic [31:0]  so, bo;
  logic [W-1:0] d2;

  initial begin
    rstn = 1'b1; cfg_enable = 1'b0; cfg_mode = 2'd0; cfg_delay = 32'd0; cfg_width = 32'd0;
    clr_overrun = 1'b0; sync_in = 1'b0; data_in_valid = 1'b0; data_in_I = '0; data_in_Q = '0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_sync", sync_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", pulse_count, 16'd0);
    chk("rst_data", data_out_I, 64'd0);
    chk("rst_valid", data_out_valid, 1'b0);
    rstn = 1'b0;
    cfg_enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // ONESHOT, delay 0, width 3
    data_free = 1'b0;
    data_in_I = 64'h4444_3333_2222_1234;
    cfg_mode = 2'd0; cfg_delay = 32'd0; cfg_width = 32'd3;
    run_pulse(6, 0, 1'b0, so, bo, d2);
    chk("A_sync", so, 32'h0E);
    chk("A_busy", bo, 32'h07);
    chk("A_data", d2[15:0], 16'h1234);
    chk("A_count", pulse_count, 16'd1);
    data_free = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // ONESHOT, delay 5, width 4, ignored second edge
    cfg_delay = 32'd5; cfg_width = 32'd4;
    run_pulse(12, 7, 1'b0, so, bo, d2);
    chk("B_sync", so, 32'h3C0);
    chk("B_busy", bo, 32'h1FF);
    chk("B_overrun", overrun, 1'b1);
    chk("B_count", pulse_count, 16'd2);
    for (int i = 0; i < 3; i++) tick();

    // Mode 3 behaves as ONESHOT; set wins over clear in the same cycle
    cfg_mode = 2'd3; cfg_delay = 32'd3; cfg_width = 32'd3;
    run_pulse(8, 2, 1'b1, so, bo, d2);
    chk("C_sync", so, 32'h70);
    chk("C_overrun", overrun, 1'b1);
    chk("C_count", pulse_count, 16'd3);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("C_clear", overrun, 1'b0);
    for (int i = 0; i < 3; i++) tick();

    // RETRIGGER, delay 2, width 10, edges at T and T+6
    cfg_mode = 2'd1; cfg_delay = 32'd2; cfg_width = 32'd10;
    run_pulse(20, 6, 1'b0, so, bo, d2);
    chk("D_sync", so, 32'h7FE38);
    chk("D_busy", bo, 32'h3FFFF);
    chk("D_count", pulse_count, 16'd5);
    chk("D_overrun", overrun, 1'b0);
    for (int i = 0; i < 3; i++) tick();

    // Zero width: edge ignored
    cfg_mode = 2'd0; cfg_delay = 32'd0; cfg_width = 32'd0;
    run_pulse(4, 0, 1'b0, so, bo, d2);
    chk("E_sync", so, 32'h0);
    chk("E_busy", bo, 32'h0);
    chk("E_count", pulse_count, 16'd5);

    // CONTINUOUS with all four channels
    cfg_enable = 1'b0;
    tick();
    cfg_mode = 2'd2;
    data_free = 1'b0;
    data_in_I = 64'hA1A2_B1B2_C1C2_D1D2;
    data_in_Q = 64'h1357_2468_9ACE_BDF0;
    cfg_enable = 1'b1;
    tick();
    chk("F_sync0", sync_out, 1'b0);
    chk("F_count", pulse_count, 16'd6);
    tick();
    chk("F_sync1", sync_out, 1'b1);
    chk("F_dataI", data_out_I, 64'hA1A2_B1B2_C1C2_D1D2);
    chk("F_dataQ", data_out_Q, 64'h1357_2468_9ACE_BDF0);
    data_in_I = 64'h0F0F_F0F0_5A5A_A5A5;
    tick();
    chk("F_dataI2", data_out_I, 64'h0F0F_F0F0_5A5A_A5A5);
    cfg_enable = 1'b0;
    tick();
    chk("F_off_sync", sync_out, 1'b0);
    chk("F_off_data", data_out_I, 64'd0);
    chk("F_off_busy", busy, 1'b0);

    // Asynchronous reset in the middle of an open gate
    cfg_enable = 1'b1; cfg_mode = 2'd0; cfg_delay = 32'd0; cfg_width = 32'd8;
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    tick();
    tick();
    chk("G_open", sync_out, 1'b1);
    #2 rstn = 1'b1;
    #1;
    chk("G_sync", sync_out, 1'b0);
    chk("G_busy", busy, 1'b0);
    chk("G_data", data_out_I, 64'd0);
    chk("G_count", pulse_count, 16'd0);
    sync_in = 1'b1;
    tick();
    tick();
    rstn = 1'b0;
    cfg_width = 32'd2;
    so = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      so[i] = sync_out;
    end
    chk("G_release_edge", so, 32'h6);
    sync_in = 1'b0;
    data_free = 1'b1;
    tick();

    // Counter wrap on the 4-bit twin
    cfg_mode = 2'd2;
    for (int i = 0; i < 14; i++) begin
      cfg_enable = 1'b1;
      tick();
      cfg_enable = 1'b0;
      tick();
    end
    chk("H_count15", pulse_count, 16'd15);
    chk("H_w_max", w_count, 4'hF);
    cfg_enable = 1'b1;
    tick();
    cfg_enable = 1'b0;
    tick();
    chk("H_count16", pulse_count, 16'd16);
    chk("H_w_wrap", w_count, 4'h0);

    // Mixed traffic in the triggered modes, checked by the model
    for (int i = 0; i < 300; i++) begin
      case (i % 3)
        0: cfg_mode = 2'd0;
        1: cfg_mode = 2'd1;
        default: cfg_mode = 2'd3;
      endcase
      cfg_enable = ($urandom_range(0, 19) != 0);
      sync_in = 1'($urandom_range(0, 1));
      cfg_delay = $urandom_range(0, 3);
      cfg_width = $urandom_range(0, 4);
      clr_overrun = ($urandom_range(0, 7) == 0);
      tick();
    end
    clr_overrun = 1'b0;
    sync_in = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
